gray_stream_decoder: RTL and testbench
======================================

Name: gray_stream_decoder

Overview:
Streaming Gray-to-binary decoder with valid/ready handshake on both sides; it is the receiving end of a Gray-coded counter or position stream.
- Each accepted Gray word is decoded to binary in a registered stage.
- Each result is classified against the previously accepted sample as STAY, UP, DOWN or step error.
- Step errors are counted in a saturating counter.
- It sits between a Gray-coded source (encoder, sensor, counter) and binary-domain consumers.

Parameters:
WIDTH, 4, width of Gray input and binary output (>=2)
ERR_CNT_W, 8, width of saturating step-error counter (>=1)
POS_W, 16, width of position accumulator (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream word available
in_ready  output  1  block can accept a word this cycle
in_gray  input  WIDTH  Gray-coded input word
out_valid  output  1  output register holds a result
out_ready  input  1  downstream accepts result this cycle
out_bin  output  WIDTH  decoded binary value
out_cls  output  2  classification: 00 STAY, 01 UP, 10 DOWN, 11 ERR
out_first  output  1  result is first sample since reset (no reference)
err_clr  input  1  synchronous clear of err_count
err_count  output  ERR_CNT_W  saturating count of ERR classifications accepted

Behaviour:
- Clock and reset: one clock, clk; rst asynchronous active-high. Reset values:
  - out_valid=0, out_bin=0, out_cls=00, out_first=0, err_count=0.
  - Internal prev_bin=0; internal first_pending=1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, one-entry register slice).
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Output fields are stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle. A word accepted at edge N appears with out_valid=1 after edge N.
  - Full throughput of 1 word/cycle when out_ready is held high.
- On input transfer:
  - out_valid<=1.
  - Decode: out_bin[WIDTH-1]=g[WIDTH-1]; out_bin[i]=out_bin[i+1]^g[i] for i down to 0.
  - Compute delta=(bin - prev_bin) mod 2^WIDTH.
  - If first_pending: out_cls=STAY, out_first=1, first_pending<=0.
  - Otherwise out_first=0 and classify the delta:
    - delta=0 -> STAY.
    - delta=1 -> UP.
    - delta=2^WIDTH-1 -> DOWN.
    - any other delta -> ERR.
  - prev_bin<=bin (ERR samples also become the new reference).
- No input transfer while an output transfer occurs: out_valid<=0.
- Wrap-around: 15->0 is UP and 0->15 is DOWN (WIDTH=4). This is not an error.
- err_count:
  - +1 on each input transfer classified ERR; saturates at all-ones and stays there.
  - err_clr alone -> 0.
  - err_clr in the same cycle as an ERR transfer -> 1.
- Reset mid-stream: any held output is discarded (out_valid=0). The next accepted word is treated as first.

Optional Feature:
Macro GRAY_POS_ACC_EN.
- Defined: adds output port pos, POS_W bits, two's-complement.
  - Reset value 0.
  - On input transfer: +1 on UP, -1 on DOWN, unchanged on STAY, ERR or first sample.
  - Wraps modulo 2^POS_W.
  - Updates in the same edge as out_cls.
- Not defined: port pos and its logic are absent; all other behaviour is identical.

Test Plan:
- Up-count: WIDTH=4, reset, send Gray 0000,0001,0011,0010,0110 with out_ready=1 -> out_bin 0,1,2,3,4; out_cls STAY(first=1),UP,UP,UP,UP; err_count=0; out_valid one cycle after each in_valid.
- Wrap/down: send 0000 then 1000 then 1001 -> out_bin 0,15,14; cls STAY(first),DOWN,DOWN; with GRAY_POS_ACC_EN, pos=-2 (0xFFFE).
- Step error: send 0000 then 0110 then 0111 -> bins 0,4,5; cls STAY,ERR,UP; err_count=1; err_clr pulsed on the ERR transfer cycle -> err_count=1; err_clr alone later -> 0.
- Backpressure: hold out_ready=0 after first word 0001 -> in_ready=0, out_bin=1 stable with in_valid=1 and in_gray=0011 held; release out_ready -> 0011 accepted on the same edge, out_bin=2 next cycle, no word lost or duplicated.
- Saturation: ERR_CNT_W=2, alternate 0000/0110 for 6 words -> 5 ERRs, err_count stops at 3.
- Reset mid-operation: assert rst asynchronously while out_valid=1 -> out_valid=0 and err_count=0 immediately; next word 0110 -> out_bin=4, out_first=1, cls STAY.

Source files
------------

// File: rtl/gray_stream_decoder.sv
// Streaming Gray-to-binary decoder with a one-entry output register slice,
// step classification and a saturating step-error counter. Optional position
// accumulator when GRAY_POS_ACC_EN is defined.
module gray_stream_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int POS_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic [1:0]           out_cls,
  output logic                 out_first,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef GRAY_POS_ACC_EN
  ,
  output logic [POS_W-1:0]     pos
`endif
);

  typedef enum logic [1:0] {
    CLS_STAY = 2'b00,
    CLS_UP   = 2'b01,
    CLS_DOWN = 2'b10,
    CLS_ERR  = 2'b11
  } cls_t;

  if (WIDTH < 2 || ERR_CNT_W < 1 || POS_W < 1) begin : g_bad_param
    $error("gray_stream_decoder: illegal parameter value");
  end

  logic [WIDTH-1:0] prev_bin;
  logic             first_pending;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] delta;
  cls_t             cls;
  logic             in_fire;
  logic             out_fire;
  logic             err_hit;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(in_gray >> i);
    end
  end

  always_comb begin
    delta = bin - prev_bin;
    cls   = CLS_STAY;
    if (!first_pending) begin
      if (delta == '0)
        cls = CLS_STAY;
      else if (delta == WIDTH'(1))
        cls = CLS_UP;
      else if (delta == {WIDTH{1'b1}})
        cls = CLS_DOWN;
      else
        cls = CLS_ERR;
    end
  end

  assign err_hit = in_fire && (cls == CLS_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_bin       <= '0;
      out_cls       <= CLS_STAY;
      out_first     <= 1'b0;
      prev_bin      <= '0;
      first_pending <= 1'b1;
    end else if (in_fire) begin
      out_valid     <= 1'b1;
      out_bin       <= bin;
      out_cls       <= cls;
      out_first     <= first_pending;
      prev_bin      <= bin;
      first_pending <= 1'b0;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // A clear coinciding with an error keeps that error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (err_clr)
      err_count <= err_hit ? ERR_CNT_W'(1) : '0;
    else if (err_hit && (err_count != {ERR_CNT_W{1'b1}}))
      err_count <= err_count + ERR_CNT_W'(1);
  end

`ifdef GRAY_POS_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pos <= '0;
    else if (in_fire && cls == CLS_UP)
      pos <= pos + POS_W'(1);
    else if (in_fire && cls == CLS_DOWN)
      pos <= pos - POS_W'(1);
  end
`endif

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Self-checking bench for gray_stream_decoder: table-driven streams plus
// hand-written backpressure, error-clear, saturation and reset sequences.
module tb_gray_stream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] in_gray = 4'b0000;

  logic       in_ready, out_valid, out_first;
  logic [3:0] out_bin;
  logic [1:0] out_cls;
  logic [7:0] err_count;

  logic       in_ready2, out_valid2, out_first2;
  logic [3:0] out_bin2;
  logic [1:0] out_cls2;
  logic [1:0] err_count2;
`ifdef GRAY_POS_ACC_EN
  logic [15:0] pos, pos2;
`endif

  gray_stream_decoder #(.WIDTH(4), .ERR_CNT_W(8), .POS_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_cls(out_cls), .out_first(out_first),
    .err_clr(err_clr), .err_count(err_count)
`ifdef GRAY_POS_ACC_EN
    , .pos(pos)
`endif
  );

  gray_stream_decoder #(.WIDTH(4), .ERR_CNT_W(2), .POS_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_gray(in_gray), .out_valid(out_valid2), .out_ready(out_ready),
    .out_bin(out_bin2), .out_cls(out_cls2), .out_first(out_first2),
    .err_clr(err_clr), .err_count(err_count2)
`ifdef GRAY_POS_ACC_EN
    , .pos(pos2)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [1:0] STAY = 2'b00, UP = 2'b01, DOWN = 2'b10, ERR = 2'b11;

  typedef struct {
    bit          do_rst;
    logic [3:0]  g;
    logic [3:0]  bin;
    logic [1:0]  cls;
    logic        first;
    logic [7:0]  errc;
    logic [15:0] pos;
  } vec_t;

  vec_t vecs[13];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_bin", 32'(out_bin), 32'd0);
    chk("rst out_cls", 32'(out_cls), 32'd0);
    chk("rst out_first", 32'(out_first), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef GRAY_POS_ACC_EN
    chk("rst pos", 32'(pos), 32'd0);
`endif
  endtask

  task automatic send(input logic [3:0] g);
    in_valid = 1'b1;
    in_gray  = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // up-count
    vecs[0]  = '{1'b1, 4'b0000, 4'd0,  STAY, 1'b1, 8'd0, 16'h0000};
    vecs[1]  = '{1'b0, 4'b0001, 4'd1,  UP,   1'b0, 8'd0, 16'h0001};
    vecs[2]  = '{1'b0, 4'b0011, 4'd2,  UP,   1'b0, 8'd0, 16'h0002};
    vecs[3]  = '{1'b0, 4'b0010, 4'd3,  UP,   1'b0, 8'd0, 16'h0003};
    vecs[4]  = '{1'b0, 4'b0110, 4'd4,  UP,   1'b0, 8'd0, 16'h0004};
    // wrap down then back up across 15 -> 0
    vecs[5]  = '{1'b1, 4'b0000, 4'd0,  STAY, 1'b1, 8'd0, 16'h0000};
    vecs[6]  = '{1'b0, 4'b1000, 4'd15, DOWN, 1'b0, 8'd0, 16'hFFFF};
    vecs[7]  = '{1'b0, 4'b1001, 4'd14, DOWN, 1'b0, 8'd0, 16'hFFFE};
    vecs[8]  = '{1'b0, 4'b1000, 4'd15, UP,   1'b0, 8'd0, 16'hFFFF};
    vecs[9]  = '{1'b0, 4'b0000, 4'd0,  UP,   1'b0, 8'd0, 16'h0000};
    // step error
    vecs[10] = '{1'b1, 4'b0000, 4'd0,  STAY, 1'b1, 8'd0, 16'h0000};
    vecs[11] = '{1'b0, 4'b0110, 4'd4,  ERR,  1'b0, 8'd1, 16'h0000};
    vecs[12] = '{1'b0, 4'b0111, 4'd5,  UP,   1'b0, 8'd1, 16'h0001};

    @(posedge clk);
    #1;
    for (int k = 0; k < 13; k++) begin
      if (vecs[k].do_rst) do_reset();
      send(vecs[k].g);
      chk("vec out_valid", 32'(out_valid), 32'd1);
      chk("vec out_bin", 32'(out_bin), 32'(vecs[k].bin));
      chk("vec out_cls", 32'(out_cls), 32'(vecs[k].cls));
      chk("vec out_first", 32'(out_first), 32'(vecs[k].first));
      chk("vec err_count", 32'(err_count), 32'(vecs[k].errc));
`ifdef GRAY_POS_ACC_EN
      chk("vec pos", 32'(pos), 32'(vecs[k].pos));
`endif
    end
    @(posedge clk);
    #1;
    chk("idle out_valid", 32'(out_valid), 32'd0);

    // backpressure: held word must be taken on the release edge, exactly once
    do_reset();
    out_ready = 1'b0;
    send(4'b0001);
    chk("bp first bin", 32'(out_bin), 32'd1);
    in_valid = 1'b1;
    in_gray  = 4'b0011;
    #1;
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp held valid", 32'(out_valid), 32'd1);
    chk("bp held bin", 32'(out_bin), 32'd1);
    chk("bp held first", 32'(out_first), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready high", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp next bin", 32'(out_bin), 32'd2);
    chk("bp next cls", 32'(out_cls), 32'(UP));
    chk("bp next valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("bp drained", 32'(out_valid), 32'd0);

    // err_clr together with an ERR transfer, then alone
    do_reset();
    send(4'b0000);
    send(4'b0110);
    send(4'b0000);
    chk("clr pre count", 32'(err_count), 32'd2);
    err_clr = 1'b1;
    send(4'b0110);
    chk("clr with err", 32'(err_count), 32'd1);
    chk("clr with err sat", 32'(err_count2), 32'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr alone", 32'(err_count), 32'd0);
    chk("clr alone sat", 32'(err_count2), 32'd0);

    // saturation of a 2-bit counter
    do_reset();
    for (int j = 0; j < 6; j++) begin
      send((j % 2 == 0) ? 4'b0000 : 4'b0110);
      chk("sat wide count", 32'(err_count), 32'(j));
      chk("sat narrow count", 32'(err_count2), 32'((j > 3) ? 3 : j));
    end

    // asynchronous reset while a result is held
    do_reset();
    send(4'b0000);
    send(4'b0110);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid held valid", 32'(out_valid), 32'd1);
    chk("mid held errc", 32'(err_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst valid", 32'(out_valid), 32'd0);
    chk("mid rst errc", 32'(err_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'b0110);
    chk("mid post bin", 32'(out_bin), 32'd4);
    chk("mid post first", 32'(out_first), 32'd1);
    chk("mid post cls", 32'(out_cls), 32'(STAY));
`ifdef GRAY_POS_ACC_EN
    chk("mid post pos", 32'(pos), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
